mult_sequencer: RTL and testbench



---
 rtl/mult_seq_pkg.sv | 15 +
 rtl/mult_shift_add_dp.sv | 55 +++++
 rtl/mult_sequencer.sv | 93 +++++++++
 tb/tb_mult_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared constants and FSM state encoding for the iterative multiplier.
package mult_seq_pkg;

  localparam int DATA_W_DEF = 32;

  // ALU control code that selects the multiplier; must track the ALU decoder.
  localparam logic [3:0] MULT_OP = 4'd8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier, one adder.
module mult_shift_add_dp
  import mult_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              mplier_lsb_o,
  output logic              mplier_rest_zero_o
);

  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = operand_a_i;
      mplier_d = operand_b_i;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc_o              = acc_q;
  assign mplier_lsb_o       = mplier_q[0];
  assign mplier_rest_zero_o = (mplier_q >> 1) == '0;

endmodule

// File: rtl/mult_sequencer.sv
// Iterative multiplier controller for the EX stage; returns the low DATA_W product bits.
// Optional MULT_EARLY_TERM_EN ends the RUN phase once no multiplier bits remain.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             load, step, done_now;
  logic             mplier_lsb, mplier_rest_zero;

  mult_shift_add_dp #(.DATA_W(DATA_W)) u_dp (
    .clk                (clk),
    .arst_n             (arst_n),
    .load_i             (load),
    .step_i             (step),
    .operand_a_i        (operand_a_i),
    .operand_b_i        (operand_b_i),
    .acc_o              (result_o),
    .mplier_lsb_o       (mplier_lsb),
    .mplier_rest_zero_o (mplier_rest_zero)
  );

`ifdef MULT_EARLY_TERM_EN
  // Decided on the pre-shift multiplier, so RUN always lasts at least one cycle.
  assign done_now = (cnt_q == '0) || mplier_rest_zero;
  logic unused_lsb;
  assign unused_lsb = mplier_lsb;
`else
  assign done_now = (cnt_q == '0);
  logic unused_flags;
  assign unused_flags = mplier_lsb ^ mplier_rest_zero;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load           = 1'b0;
    step           = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          load    = 1'b1;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          step    = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (done_now) state_d = DONE;
        end
      end
      DONE: begin
        // start_i here still belongs to the finishing instruction, so it is ignored.
        result_valid_o = !flush_i;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: vector table plus flush, reset and back-to-back sequences.
module tb_mult_sequencer;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start_i, flush_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        stall_o, result_valid_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  mult_sequencer dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .start_i        (start_i),
    .flush_i        (flush_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int run_len(input logic [31:0] b);
    int h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i + 1;
    return EARLY ? ((h == 0) ? 1 : h) : 32;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int cycles = 0;
    int stall_bad = 0;
    start_i = 1'b1; operand_a_i = a; operand_b_i = b;
    #1;
    check({tag, " stall_t0"}, 64'(stall_o), 64'd1);
    step();
    start_i = 1'b0;
    #1;
    while (!result_valid_o && cycles < 200) begin
      if (stall_o !== 1'b1) stall_bad++;
      cycles++;
      step();
      #1;
    end
    check({tag, " run_cycles"}, 64'(cycles), 64'(run_len(b)));
    check({tag, " stall_during_run"}, 64'(stall_bad), 64'd0);
    check({tag, " valid_done"}, 64'(result_valid_o), 64'd1);
    check({tag, " result"}, 64'(result_o), 64'(exp));
    check({tag, " stall_done"}, 64'(stall_o), 64'd0);
    step();
    #1;
    check({tag, " valid_one_cycle"}, 64'(result_valid_o), 64'd0);
  endtask

  initial begin
    int t;
    int pulses;
    int flush_at;

    vecs[0]  = '{32'd7,        32'd6,        32'd42};
    vecs[1]  = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB};
    vecs[2]  = '{32'h80000000, 32'd2,        32'h00000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[4]  = '{32'd0,        32'd0,        32'd0};
    vecs[5]  = '{32'h12345678, 32'h10,       32'h23456780};
    vecs[6]  = '{32'd1000,     32'd1000,     32'd1000000};
    vecs[7]  = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    vecs[8]  = '{32'd3,        32'd5,        32'd15};
    vecs[9]  = '{32'd123,      32'd0,        32'd0};
    vecs[10] = '{32'd1,        32'h80000000, 32'h80000000};
    vecs[11] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};

    arst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    operand_a_i = '0; operand_b_i = '0;
    repeat (3) step();
    #1;
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset valid", 64'(result_valid_o), 64'd0);
    check("reset result", 64'(result_o), 64'd0);
    arst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Flush wins over start in IDLE: no capture, no stall.
    start_i = 1'b1; flush_i = 1'b1; operand_a_i = 32'd4; operand_b_i = 32'd4;
    #1;
    check("idle_flush stall", 64'(stall_o), 64'd0);
    step();
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("idle_flush no_run", 64'(stall_o), 64'd0);

    // Flush mid-operation.
    flush_at = (run_len(32'd9) >= 10) ? 10 : 2;
    start_i = 1'b1; operand_a_i = 32'd9; operand_b_i = 32'd9;
    for (int c = 0; c < flush_at; c++) step();
    flush_i = 1'b1;
    #1;
    check("flush stall_in_flush_cycle", 64'(stall_o), 64'd0);
    step();
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    check("flush back_to_idle", 64'(stall_o), 64'd0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (result_valid_o) pulses++;
      step();
      #1;
    end
    check("flush no_valid_pulse", 64'(pulses), 64'd0);

    // Back-to-back with start held high.
    start_i = 1'b1; operand_a_i = 32'd5; operand_b_i = 32'd5;
    t = 0;
    do begin step(); #1; t++; end while (!result_valid_o && t < 200);
    check("b2b op1 done_time", 64'(t), 64'(run_len(32'd5) + 1));
    check("b2b op1 result", 64'(result_o), 64'd25);
    operand_a_i = 32'd3; operand_b_i = 32'd4;
    step();
    #1;
    check("b2b op2 capture_stall", 64'(stall_o), 64'd1);
    t = 0;
    do begin step(); #1; t++; end while (!result_valid_o && t < 200);
    check("b2b op2 done_time", 64'(t), 64'(run_len(32'd4) + 1));
    check("b2b op2 result", 64'(result_o), 64'd12);
    start_i = 1'b0;
    step();

    // Reset mid-operation, then a fresh multiply.
    start_i = 1'b1; operand_a_i = 32'd100; operand_b_i = 32'hFFFF;
    repeat (5) step();
    arst_n = 1'b0; start_i = 1'b0;
    step();
    #1;
    check("midrst stall", 64'(stall_o), 64'd0);
    check("midrst valid", 64'(result_valid_o), 64'd0);
    check("midrst result", 64'(result_o), 64'd0);
    arst_n = 1'b1;
    step();
    do_op(32'd2, 32'd3, 32'd6, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
